// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: HALTED -> FETCH1 -> FETCH2 (MEM_WAIT) -> FETCH3 -> PAUSE.
// Ports: Clk, Reset (sync, active-high), Run, Continue in; datapath gates/loads,
//        memory strobes (active-low), Fetch_Done and Paused out. Moore outputs only.
module fetch_control #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic Continue,
    output logic GATEPC,
    output logic GATEMDR,
    output logic LD_MAR,
    output logic LD_MDR,
    output logic LD_IR,
    output logic LD_PC,
    output logic PCMUX_EN,
    output logic MIO_EN,
    output logic Mem_CE_N,
    output logic Mem_OE_N,
    output logic Mem_WE_N,
    output logic Fetch_Done,
    output logic Paused
);

    typedef enum logic [2:0] {
        HALTED,
        FETCH1,
        FETCH2,
        FETCH3,
        PAUSE1,
        PAUSE2
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HALTED: if (Run) state_d = FETCH1;
            FETCH1: begin
                state_d = FETCH2;
                cnt_d   = '0;
            end
            FETCH2: begin
                // Counter holds at LAST_WAIT on exit, so it never wraps.
                if (cnt_q == LAST_WAIT) state_d = FETCH3;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            FETCH3: state_d = PAUSE1;
            PAUSE1: begin
                if (!Run)          state_d = HALTED;
                else if (Continue) state_d = PAUSE2;
            end
            // Wait for Continue release so one press gives one fetch.
            PAUSE2: if (!Continue) state_d = FETCH1;
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        GATEPC     = 1'b0;
        GATEMDR    = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_PC      = 1'b0;
        PCMUX_EN   = 1'b0;
        MIO_EN     = 1'b0;
        Mem_CE_N   = 1'b1;
        Mem_OE_N   = 1'b1;
        Mem_WE_N   = 1'b1;
        Fetch_Done = 1'b0;
        Paused     = 1'b0;
        case (state_q)
            FETCH1: begin
                GATEPC   = 1'b1;
                LD_MAR   = 1'b1;
                PCMUX_EN = 1'b1;
                LD_PC    = 1'b1;
            end
            FETCH2: begin
                Mem_CE_N = 1'b0;
                Mem_OE_N = 1'b0;
                MIO_EN   = 1'b1;
                LD_MDR   = (cnt_q == LAST_WAIT);
            end
            FETCH3: begin
                GATEMDR    = 1'b1;
                LD_IR      = 1'b1;
                Fetch_Done = 1'b1;
            end
            PAUSE1, PAUSE2: Paused = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control at MEM_WAIT = 2, 1 and 15.
// Output vector order: GATEPC GATEMDR LD_MAR LD_MDR LD_IR LD_PC PCMUX MIO CE_N OE_N WE_N FD P
module tb_fetch_control;

    localparam int unsigned MW [3] = '{2, 1, 15};

    localparam logic [12:0] O_HALT = 13'b0_0_0_0_0_0_0_0_1_1_1_0_0;
    localparam logic [12:0] O_F1   = 13'b1_0_1_0_0_1_1_0_1_1_1_0_0;
    localparam logic [12:0] O_F2   = 13'b0_0_0_0_0_0_0_1_0_0_1_0_0;
    localparam logic [12:0] O_F2L  = 13'b0_0_0_1_0_0_0_1_0_0_1_0_0;
    localparam logic [12:0] O_F3   = 13'b0_1_0_0_1_0_0_0_1_1_1_1_0;
    localparam logic [12:0] O_P    = 13'b0_0_0_0_0_0_0_0_1_1_1_0_1;

    logic clk = 1'b0;
    logic rst  [3];
    logic run  [3];
    logic cont [3];
    wire [12:0] o [3];

    int total = 0;
    int fails = 0;
    bit inv_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fetch_control #(.MEM_WAIT(MW[g])) u_dut (
            .Clk       (clk),
            .Reset     (rst[g]),
            .Run       (run[g]),
            .Continue  (cont[g]),
            .GATEPC    (o[g][12]),
            .GATEMDR   (o[g][11]),
            .LD_MAR    (o[g][10]),
            .LD_MDR    (o[g][9]),
            .LD_IR     (o[g][8]),
            .LD_PC     (o[g][7]),
            .PCMUX_EN  (o[g][6]),
            .MIO_EN    (o[g][5]),
            .Mem_CE_N  (o[g][4]),
            .Mem_OE_N  (o[g][3]),
            .Mem_WE_N  (o[g][2]),
            .Fetch_Done(o[g][1]),
            .Paused    (o[g][0])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int i, input logic [12:0] exp, input string tag);
        total++;
        assert (o[i] === exp) else begin
            fails++;
            $error("FAIL %s inst%0d observed=%b expected=%b", tag, i, o[i], exp);
        end
    endtask

    // Structural invariants on every instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_on) begin
            for (int g = 0; g < 3; g++) begin
                total++;
                assert (o[g][2] === 1'b1 && !(o[g][12] && o[g][11])
                        && !(o[g][9] && o[g][8])) else begin
                    fails++;
                    $error("FAIL invariant inst%0d observed=%b expected=WE_N=1,no gate/load overlap",
                           g, o[g]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]  = 1'b1;
            run[i]  = 1'b0;
            cont[i] = 1'b0;
        end
        step();
        inv_on = 1'b1;
        chk(0, O_HALT, "reset_w2");
        chk(1, O_HALT, "reset_w1");
        chk(2, O_HALT, "reset_w15");

        // Basic fetch with Run held
        rst[0] = 1'b0;
        run[0] = 1'b1;
        step(); chk(0, O_F1,  "f1");
        step(); chk(0, O_F2,  "f2_first");
        step(); chk(0, O_F2L, "f2_last");
        step(); chk(0, O_F3,  "f3");
        step(); chk(0, O_P,   "pause1");
        step(); chk(0, O_P,   "pause1_hold");

        // Continue held 3 cycles, then released: one more fetch
        cont[0] = 1'b1;
        step(); chk(0, O_P, "pause2_a");
        step(); chk(0, O_P, "pause2_b");
        step(); chk(0, O_P, "pause2_c");
        cont[0] = 1'b0;
        step(); chk(0, O_F1,  "cont_f1");
        step(); chk(0, O_F2,  "cont_f2");
        step(); chk(0, O_F2L, "cont_f2l");
        step(); chk(0, O_F3,  "cont_f3");
        step(); chk(0, O_P,   "cont_pause1");
        step(); chk(0, O_P,   "cont_no_refetch");

        // Run dropped mid-FETCH2: fetch completes then halts
        cont[0] = 1'b1;
        step(); chk(0, O_P, "drop_pause2");
        cont[0] = 1'b0;
        step(); chk(0, O_F1, "drop_f1");
        step(); chk(0, O_F2, "drop_f2");
        run[0] = 1'b0;
        step(); chk(0, O_F2L,  "drop_f2l");
        step(); chk(0, O_F3,   "drop_f3");
        step(); chk(0, O_P,    "drop_pause1");
        step(); chk(0, O_HALT, "drop_halted");
        step(); chk(0, O_HALT, "drop_stay");

        // Run and Continue together from HALTED
        run[0]  = 1'b1;
        cont[0] = 1'b1;
        step(); chk(0, O_F1,  "rc_f1");
        step(); chk(0, O_F2,  "rc_f2");
        step(); chk(0, O_F2L, "rc_f2l");
        step(); chk(0, O_F3,  "rc_f3");
        step(); chk(0, O_P,   "rc_pause1");
        step(); chk(0, O_P,   "rc_pause2");
        cont[0] = 1'b0;
        step(); chk(0, O_F1,  "rc_f1_again");

        // Reset in first FETCH2 cycle
        step(); chk(0, O_F2, "rst_f2");
        rst[0] = 1'b1;
        step(); chk(0, O_HALT, "rst_mid_f2");
        rst[0] = 1'b0;
        run[0] = 1'b0;
        step(); chk(0, O_HALT, "rst_no_ldmdr");
        step(); chk(0, O_HALT, "rst_no_ldir");

        // MEM_WAIT = 1
        rst[1] = 1'b0;
        run[1] = 1'b1;
        step(); chk(1, O_F1,  "w1_f1");
        step(); chk(1, O_F2L, "w1_f2l");
        step(); chk(1, O_F3,  "w1_f3");
        run[1] = 1'b0;
        step(); chk(1, O_P,    "w1_pause1");
        step(); chk(1, O_HALT, "w1_halted");

        // MEM_WAIT = 15
        rst[2] = 1'b0;
        run[2] = 1'b1;
        step(); chk(2, O_F1, "w15_f1");
        for (int k = 0; k < 14; k++) begin
            step(); chk(2, O_F2, $sformatf("w15_f2_%0d", k));
        end
        step(); chk(2, O_F2L, "w15_f2l");
        step(); chk(2, O_F3,  "w15_f3");
        step(); chk(2, O_P,   "w15_pause1");

        // Reset wins over Run and Continue
        cont[2] = 1'b1;
        rst[2]  = 1'b1;
        step(); chk(2, O_HALT, "w15_rst_prio");
        step(); chk(2, O_HALT, "w15_rst_hold");

        inv_on = 1'b0;
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
